seven_seg_scan: RTL and testbench

Time-multiplexed 4-digit seven-segment display driver, sitting directly downstream of the score/number formatter. It consumes four 4-bit digit codes plus a per-digit blank mask. It scans one digit at a time with a programmable refresh rate, a ghosting guard interval and an optional whole-display blink. It drives the board's common-anode display with active-low anode and segment lines.

---
 rtl/seven_seg_scan.sv | 116 +++++++++++
 tb/tb_seven_seg_scan.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner with per-slot guard interval,
// per-digit blanking and optional whole-display blink. All outputs registered.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_TICKS  = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] blank,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    slot;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          tick;
  logic          guard;
  logic          show;
  logic [3:0]    cur_digit;

  // Active-high {g,f,e,d,c,b,a}; A..F render as A,b,C,d,E,F.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    tick  = (prescaler == PRE_MAX);
    guard = (prescaler < GUARD_END);
    case (slot)
      2'd0:    cur_digit = digit0;
      2'd1:    cur_digit = digit1;
      2'd2:    cur_digit = digit2;
      default: cur_digit = digit3;
    endcase
    show = !guard && !blank[slot] && !(blink && blink_phase);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      slot      <= 2'd0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) slot <= slot + 2'd1;
    end
  end

  // Blink counts slot ticks only while enabled; disabling clears it immediately.
  always_ff @(posedge clk) begin
    if (reset || !blink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Outputs sample the pre-edge slot/prescaler/inputs, so they trail by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      dp <= 1'b1;
      if (show) begin
        an  <= ~(4'b0001 << slot);
        seg <= ~decode(cur_digit);
      end else begin
        an  <= 4'b1111;
        seg <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios plus random traffic, checked
// cycle by cycle against a time-based reference model.
module tb_seven_seg_scan;

  localparam int RD = 4;
  localparam int BC = 1;
  localparam int BT = 2;

  logic       clk;
  logic       reset;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] blank;
  logic       blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycles since reset release and slot ticks seen while blinking.
  int m_t  = 0;
  int m_bt = 0;

  logic [11:0] exp_q[$];
  logic [6:0]  glyph [16];

  seven_seg_scan #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .BLINK_TICKS (BT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .digit0(digit0),
    .digit1(digit1),
    .digit2(digit2),
    .digit3(digit3),
    .blank (blank),
    .blink (blink),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_slot();
    return (m_t / RD) % 4;
  endfunction

  function automatic bit m_dark();
    return blink && (((m_bt / BT) % 2) == 1);
  endfunction

  function automatic logic [11:0] model_out();
    int         s;
    logic [3:0] d;
    logic [3:0] a;
    if (reset) return {4'b1111, 7'h7F, 1'b1};
    s = m_slot();
    case (s)
      0:       d = digit0;
      1:       d = digit1;
      2:       d = digit2;
      default: d = digit3;
    endcase
    if ((m_t % RD) < BC || blank[s] || m_dark()) return {4'b1111, 7'h7F, 1'b1};
    a = 4'b1111;
    a[s] = 1'b0;
    return {a, ~glyph[d], 1'b1};
  endfunction

  task automatic model_advance();
    if (reset) begin
      m_t  = 0;
      m_bt = 0;
    end else begin
      if (!blink) m_bt = 0;
      else if ((m_t % RD) == RD - 1) m_bt++;
      m_t++;
    end
  endtask

  // One clock: predict, clock, advance model, compare 1 time unit after the edge.
  task automatic step();
    logic [11:0] e;
    exp_q.push_back(model_out());
    @(posedge clk);
    model_advance();
    #1;
    e = exp_q.pop_front();
    check("an", 32'(an), 32'(e[11:8]));
    check("seg", 32'(seg), 32'(e[7:1]));
    check("dp", 32'(dp), 32'(e[0]));
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask

  initial begin
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    bit found;
    glyph = tbl;

    // Reset hold and release
    reset = 1'b1; blink = 1'b0; blank = 4'b0000;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    repeat (3) step();
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    step();
    check("rel_guard_an", 32'(an), 32'hF);
    step();
    check("rel_an", 32'(an), 32'hE);
    check("rel_seg", 32'(seg), 32'h79);

    // Scan order
    repeat (20) step();

    // Blanking slots 2 and 3
    set_digits(4'd0, 4'd0, 4'd2, 4'd1);
    blank = 4'b1100;
    repeat (16) step();

    // Hex glyphs
    blank = 4'b0000;
    set_digits(4'hF, 4'hE, 4'h1, 4'hD);
    repeat (16) step();

    // Blink for 16 ticks, then drop it inside a dark phase
    blink = 1'b1;
    repeat (16 * RD) step();
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_dark() && (m_t % RD) == 2) found = 1'b1;
      else step();
    end
    check("blink_dark_found", 32'(found), 32'd1);
    step();
    check("blink_dark_an", 32'(an), 32'hF);
    blink = 1'b0;
    step();
    check("blink_relight_on", 32'(an != 4'hF), 32'd1);
    repeat (8) step();

    // Mid-scan reset while slot 2 is displayed
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_slot() == 2 && (m_t % RD) == 2) found = 1'b1;
      else step();
    end
    check("slot2_found", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    repeat (12) step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) blank = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) blink = ~blink;
      reset = ($urandom_range(0, 150) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
